// File: rtl/ysyx_22040632_imif_sram_pkg.sv
// Shared types and constants for the imif SRAM responder.
package ysyx_22040632_imif_pkg;
  localparam int IMIF_AW   = 32;
  localparam int IMIF_DW   = 64;
  localparam int IMIF_LENW = 8;
  localparam logic IMIF_REQ_RD = 1'b0;
  localparam logic IMIF_REQ_WR = 1'b1;
  localparam logic [IMIF_DW-1:0] IMIF_OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [2:0] {IDLE, LAT, RD, WR, WRSP} imif_sram_st_e;
endpackage

// File: rtl/ysyx_22040632_imif_sram_if.sv
// imif request/burst bundle; the master drives requests and write beats, the slave answers.
interface ysyx_22040632_imif_sram_if;
  import ysyx_22040632_imif_pkg::*;
  logic                 rw_valid;
  logic                 rw_ready;
  logic                 rw_req;
  logic [IMIF_AW-1:0]   rw_addr;
  logic [2:0]           rw_size;
  logic [IMIF_LENW-1:0] rw_len;
  logic [IMIF_DW-1:0]   rw_w_data;
  logic [IMIF_DW/8-1:0] w_strb;
  logic                 w_last;
  logic                 w_hs;
  logic [IMIF_DW-1:0]   data_read;
  logic                 r_hs;
  logic                 r_last;
  logic                 axi_write_ahead;

  modport master (
    output rw_valid, rw_req, rw_addr, rw_size, rw_len, rw_w_data, w_strb, w_last,
    input  rw_ready, w_hs, data_read, r_hs, r_last, axi_write_ahead
  );
  modport slave (
    input  rw_valid, rw_req, rw_addr, rw_size, rw_len, rw_w_data, w_strb, w_last,
    output rw_ready, w_hs, data_read, r_hs, r_last, axi_write_ahead
  );
endinterface

// File: rtl/ysyx_22040632_imif_sram_arr.sv
// Byte-enable 64-bit word array: synchronous write, asynchronous read, never cleared by reset.
module ysyx_22040632_imif_sram_arr
  import ysyx_22040632_imif_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IW-1:0]        i_widx,
  input  logic [IMIF_DW-1:0]   i_wdata,
  input  logic [IMIF_DW/8-1:0] i_strb,
  input  logic [IW-1:0]        i_ridx,
  output logic [IMIF_DW-1:0]   o_rdata
);
  logic [IMIF_DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < IMIF_DW/8; b++) begin
      if (i_we && i_strb[b]) r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/ysyx_22040632_imif_sram.sv
// imif slave memory model: one burst at a time after LAT_CYC cycles of latency.
// Optional random beat stalls when YSYX_22040632_IMIF_SRAM_STALL_EN is defined.
//   IDLE | ready for a request    LAT | latency countdown    RD | one read beat per cycle
//   WR   | one write beat per cycle                         WRSP | write committed pulse
module ysyx_22040632_imif_sram
  import ysyx_22040632_imif_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LAT_CYC = 2
) (
  input  logic clk,
  input  logic rrst,
  ysyx_22040632_imif_sram_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  imif_sram_st_e        r_state, w_next;
  logic                 r_req;
  logic [IMIF_AW-1:0]   r_addr;
  logic [IMIF_LENW-1:0] r_len, r_beat;
  logic [3:0]           r_cnt;
  logic                 w_go, w_last_beat, w_in_range, w_we, w_rbeat, w_wbeat;
  logic [IMIF_AW-1:0]   w_off, w_word, w_idx_full;
  logic [IW-1:0]        w_idx;
  logic [IMIF_DW-1:0]   w_rdata;
  logic                 w_unused;

`ifdef YSYX_22040632_IMIF_SRAM_STALL_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (rrst) r_lfsr <= 8'hA5;
    else      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_go = ~r_lfsr[0];
`else
  assign w_go = 1'b1;
`endif

  // Word index wraps inside the array; range is judged on the burst start address.
  assign w_off       = r_addr - BASE;
  assign w_word      = {3'b000, w_off[IMIF_AW-1:3]} + {24'd0, r_beat};
  assign w_idx_full  = w_word % 32'(DEPTH);
  assign w_idx       = w_idx_full[IW-1:0];
  assign w_in_range  = (r_addr >= BASE) && (w_off < 32'(8 * DEPTH));
  assign w_last_beat = (r_beat == r_len);
  assign w_rbeat     = (r_state == RD) && w_go;
  assign w_wbeat     = (r_state == WR) && w_go;
  assign w_we        = w_wbeat && w_in_range && !rrst;
  assign w_unused    = ^{bus.rw_size, bus.w_last, w_off[2:0], w_idx_full[IMIF_AW-1:IW]};

  always_ff @(posedge clk) begin
    if (rrst) begin
      r_state <= IDLE;
      r_req   <= IMIF_REQ_RD;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.rw_valid) begin
        r_req  <= bus.rw_req;
        r_addr <= bus.rw_addr;
        r_len  <= bus.rw_len;
        r_beat <= '0;
        r_cnt  <= 4'(LAT_CYC - 1);
      end else if (r_state == LAT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_rbeat || w_wbeat) begin
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.rw_valid) w_next = LAT;
      LAT:     if (r_cnt == 4'd0) w_next = (r_req == IMIF_REQ_RD) ? RD : WR;
      RD:      if (w_rbeat && w_last_beat) w_next = IDLE;
      WR:      if (w_wbeat && w_last_beat) w_next = WRSP;
      WRSP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.rw_ready        = 1'b0;
    bus.r_hs            = 1'b0;
    bus.r_last          = 1'b0;
    bus.w_hs            = 1'b0;
    bus.axi_write_ahead = 1'b0;
    bus.data_read       = '0;
    if (!rrst) begin
      bus.rw_ready        = (r_state == IDLE);
      bus.r_hs            = w_rbeat;
      bus.r_last          = w_rbeat && w_last_beat;
      bus.w_hs            = w_wbeat;
      bus.axi_write_ahead = (r_state == WRSP);
      if (w_rbeat) bus.data_read = w_in_range ? w_rdata : IMIF_OOR_DATA;
    end
  end

  ysyx_22040632_imif_sram_arr #(.DEPTH(DEPTH), .IW(IW)) u_arr (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wdata (bus.rw_w_data),
    .i_strb  (bus.w_strb),
    .i_ridx  (w_idx),
    .o_rdata (w_rdata)
  );
endmodule
